serial_deser: RTL and testbench

Parametrised multi-lane deserialiser with automatic word alignment. Each lane takes 2 bits per CLKS cycle from an upstream DDR capture stage. The block hunts for a sync pattern at every bit offset, confirms the boundary over several words, and then emits aligned WORD-bit words with a per-lane valid strobe. The boundary is found from the data itself, so no external frame strobe or clock-domain crossing is needed.

---
 rtl/serial_deser.sv | 138 +++++++++++++
 tb/tb_serial_deser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deser.sv
// -----------------------------------------------------------------------------
// serial_deser
//
// Multi-lane deserialiser with self-alignment. Each lane receives two bits per
// CLKS cycle (the bit on DIN[2l+1] arrived first). The lane hunts for the SYNC
// pattern at both possible bit offsets inside a pair. It confirms the word
// boundary over LOCK_CNT further words, and then emits one aligned WORD-bit
// word every WORD/2 cycles.
//
// Ports
//   CLKS       in   sole clock, rising edge
//   RSTS       in   synchronous active-high reset (wins over RETRAIN)
//   RETRAIN    in   synchronous pulse, sends every lane back to HUNT
//   DIN        in   [2*LANES]    lane l pair at [2l+1:2l], [2l+1] earlier bit
//   DOUT       out  [WORD*LANES] lane l word at [WORD*l +: WORD], MSB first
//   DVALID     out  [LANES]      one-cycle strobe when a lane's DOUT updates
//   LOCKED     out  [LANES]      lane is in LOCK
//   dbg_state  out  [2*LANES]    lane l FSM state at [2l+1:2l]
//                                (0 HUNT, 1 VERIFY, 2 LOCK)
//   dbg_ofs    out  [LANES]      lane l bit offset of the word boundary
//
// Handshake: there is no backpressure. A word is valid on DOUT only in the
// cycle where DVALID is high. The consumer must take it in that cycle. DOUT
// holds its value between strobes.
// -----------------------------------------------------------------------------
module serial_deser #(
  parameter int              LANES    = 1,
  parameter int              WORD     = 16,
  parameter logic [WORD-1:0] SYNC     = 16'hF0A5,
  parameter int              LOCK_CNT = 4
) (
  input  logic                  CLKS,
  input  logic                  RSTS,
  input  logic                  RETRAIN,
  input  logic [2*LANES-1:0]    DIN,
  output logic [WORD*LANES-1:0] DOUT,
  output logic [LANES-1:0]      DVALID,
  output logic [LANES-1:0]      LOCKED,
  output logic [2*LANES-1:0]    dbg_state,
  output logic [LANES-1:0]      dbg_ofs
);

  localparam int PW = $clog2(WORD / 2);
  localparam int CW = $clog2(LOCK_CNT + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(WORD / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_CNT - 1);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCK   = 2'd2;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // The history is one bit longer than a word, so a window that ends on
    // either bit of the newest pair can be read in the same cycle.
    logic [WORD:0]   hist;
    logic [1:0]      state;
    logic [PW-1:0]   phase;
    logic [CW-1:0]   cnt;
    logic            ofs;
    logic [WORD-1:0] dout_r;
    logic            dvalid_r;

    logic [WORD-1:0] w0;
    logic [WORD-1:0] w1;
    logic [WORD-1:0] w_sel;
    logic            boundary;

    assign w0       = hist[WORD-1:0];   // word ends on the later bit
    assign w1       = hist[WORD:1];     // word ends on the earlier bit
    assign w_sel    = ofs ? w1 : w0;
    // phase is 0 in the cycle after the HUNT match. Each later word is
    // therefore complete in hist when phase reaches WORD/2-1.
    assign boundary = (phase == PH_LAST);

    always_ff @(posedge CLKS) begin
      if (RSTS) begin
        hist     <= '0;
        state    <= S_HUNT;
        phase    <= '0;
        cnt      <= '0;
        ofs      <= 1'b0;
        dout_r   <= '0;
        dvalid_r <= 1'b0;
      end else begin
        hist     <= {hist[WORD-2:0], DIN[2*l+1], DIN[2*l]};
        dvalid_r <= 1'b0;
        if (RETRAIN) begin
          state <= S_HUNT;
        end else begin
          case (state)
            S_HUNT: begin
              // If both windows match, the even offset takes priority.
              if (w0 == SYNC) begin
                ofs   <= 1'b0;
                phase <= '0;
                cnt   <= '0;
                state <= S_VERIFY;
              end else if (w1 == SYNC) begin
                ofs   <= 1'b1;
                phase <= '0;
                cnt   <= '0;
                state <= S_VERIFY;
              end
            end
            S_VERIFY: begin
              phase <= boundary ? '0 : phase + PW'(1);
              if (boundary) begin
                if (w_sel == SYNC) begin
                  cnt <= cnt + CW'(1);
                  if (cnt == CNT_LAST) state <= S_LOCK;
                end else begin
                  // The HUNT search resumes on the following cycle.
                  state <= S_HUNT;
                end
              end
            end
            S_LOCK: begin
              phase <= boundary ? '0 : phase + PW'(1);
              if (boundary) begin
                dout_r   <= w_sel;
                dvalid_r <= 1'b1;
              end
            end
            default: state <= S_HUNT;
          endcase
        end
      end
    end

    assign DOUT[WORD*l +: WORD] = dout_r;
    assign DVALID[l]            = dvalid_r;
    assign LOCKED[l]            = (state == S_LOCK);
    assign dbg_state[2*l +: 2]  = state;
    assign dbg_ofs[l]           = ofs;
  end

endmodule

// File: tb/tb_serial_deser.sv
module tb_serial_deser;

  localparam int LANES = 4;
  localparam int WORD  = 16;
  localparam int MAXE  = 256;

  localparam logic [WORD-1:0] S_W = 16'hF0A5;

  // ---------------- clock / reset ----------------
  logic                  clks = 1'b0;
  logic                  rsts;
  logic                  retrain;
  logic [2*LANES-1:0]    din;
  logic [WORD*LANES-1:0] dout;
  logic [LANES-1:0]      dvalid;
  logic [LANES-1:0]      locked;
  logic [2*LANES-1:0]    dbg_state;
  logic [LANES-1:0]      dbg_ofs;

  always #5 clks = ~clks;

  serial_deser #(
    .LANES(LANES), .WORD(WORD), .SYNC(16'hF0A5), .LOCK_CNT(4)
  ) dut (
    .CLKS(clks), .RSTS(rsts), .RETRAIN(retrain), .DIN(din),
    .DOUT(dout), .DVALID(dvalid), .LOCKED(locked),
    .dbg_state(dbg_state), .dbg_ofs(dbg_ofs)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [WORD-1:0] exp_q[$];

  logic [1023:0]   lane_bits [LANES];
  logic [1:0]      st0   [MAXE];
  logic            lk0   [MAXE];
  logic            dv0   [MAXE];
  logic [WORD-1:0] dout0 [MAXE];
  int              lock_edge [LANES];
  int              dv_edge   [LANES];
  int              dv2_edge  [LANES];
  logic [WORD-1:0] dv_word   [LANES];
  int              dv_early;
  int              zero_viol;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_streams();
    for (int l = 0; l < LANES; l++) lane_bits[l] = '0;
  endtask

  // Word placed MSB first starting at bit position pos of the lane stream.
  task automatic put_word(input int l, input int pos, input logic [WORD-1:0] w);
    for (int i = 0; i < WORD; i++) lane_bits[l][pos+i] = w[WORD-1-i];
  endtask

  task automatic apply_reset();
    rsts    = 1'b1;
    retrain = 1'b0;
    din     = '0;
    repeat (2) @(posedge clks);
    #1;
    rsts = 1'b0;
  endtask

  // Drives pair e before edge e; samples outputs 1 time unit after edge e.
  task automatic run_stream(input int ncycles, input int retrain_edge, input int rst_edge);
    dv_early  = 0;
    zero_viol = 0;
    for (int l = 0; l < LANES; l++) begin
      lock_edge[l] = -1;
      dv_edge[l]   = -1;
      dv2_edge[l]  = -1;
      dv_word[l]   = '0;
    end
    for (int e = 0; e < ncycles; e++) begin
      for (int l = 0; l < LANES; l++) begin
        din[2*l+1] = lane_bits[l][2*e];
        din[2*l]   = lane_bits[l][2*e+1];
      end
      retrain = (e == retrain_edge);
      rsts    = (e == rst_edge);
      @(posedge clks);
      #1;
      st0[e]   = dbg_state[1:0];
      lk0[e]   = locked[0];
      dv0[e]   = dvalid[0];
      dout0[e] = dout[WORD-1:0];
      if (dout != '0 || dvalid != '0 || locked != '0) zero_viol++;
      for (int l = 0; l < LANES; l++) begin
        if (locked[l] && lock_edge[l] < 0) lock_edge[l] = e;
        if (dvalid[l]) begin
          if (lock_edge[l] < 0) dv_early++;
          if (dv_edge[l] < 0) begin
            dv_edge[l] = e;
            dv_word[l] = dout[WORD*l +: WORD];
          end else if (dv2_edge[l] < 0) begin
            dv2_edge[l] = e;
          end
        end
      end
      if (dvalid[0] && exp_q.size() > 0) check("sb_word", dout[WORD-1:0], exp_q.pop_front());
    end
    retrain = 1'b0;
    rsts    = 1'b0;
    din     = '0;
  endtask

  // Five syncs, then 1234 and BEEF, starting at bit offset skew.
  task automatic put_std(input int l, input int skew);
    for (int k = 0; k < 5; k++) put_word(l, skew + 16*k, S_W);
    put_word(l, skew + 80, 16'h1234);
    put_word(l, skew + 96, 16'hBEEF);
  endtask

  int lk_exp [LANES];
  int of_exp [LANES];
  int dv_exp [LANES];
  int skew   [LANES];

  initial begin
    skew   = '{0, 3, 8, 13};
    lk_exp = '{40, 42, 44, 47};
    of_exp = '{0, 1, 0, 1};
    dv_exp = '{48, 50, 52, 55};

    // ---- reset state ----
    apply_reset();
    check("rst_dout", dout, '0);
    check("rst_dvalid", dvalid, '0);
    check("rst_locked", locked, '0);

    // ---- even-offset lock on lane 0 ----
    clear_streams();
    put_std(0, 0);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hBEEF);
    run_stream(64, -1, -1);
    check("even_lock_edge", lock_edge[0], 40);
    check("even_ofs", dbg_ofs[0], 1'b0);
    check("even_dv_edge", dv_edge[0], 48);
    check("even_dv2_edge", dv2_edge[0], 56);
    check("even_dv_early", dv_early, 0);
    check("even_state_lock", st0[63], 2'd2);
    check("even_other_lanes", lock_edge[1], -1);
    check("even_sb_empty", exp_q.size(), 0);

    // ---- odd-offset lock (stream delayed one bit) ----
    apply_reset();
    clear_streams();
    put_std(0, 1);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hBEEF);
    run_stream(64, -1, -1);
    check("odd_lock_edge", lock_edge[0], 41);
    check("odd_ofs", dbg_ofs[0], 1'b1);
    check("odd_dv_edge", dv_edge[0], 49);
    check("odd_dv2_edge", dv2_edge[0], 57);
    check("odd_sb_empty", exp_q.size(), 0);

    // ---- verify failure: S, S, 0000, 5xS, 1234 ----
    apply_reset();
    clear_streams();
    put_word(0, 0, S_W);
    put_word(0, 16, S_W);
    put_word(0, 32, 16'h0000);
    for (int k = 3; k < 8; k++) put_word(0, 16*k, S_W);
    put_word(0, 128, 16'h1234);
    exp_q.push_back(16'h1234);
    run_stream(80, -1, -1);
    check("vf_state_e23", st0[23], 2'd1);
    check("vf_state_e24", st0[24], 2'd0);
    check("vf_state_e32", st0[32], 2'd1);
    check("vf_lock_edge", lock_edge[0], 64);
    check("vf_dv_edge", dv_edge[0], 72);
    check("vf_dv_early", dv_early, 0);
    check("vf_sb_empty", exp_q.size(), 0);

    // ---- multi-lane skew 0/3/8/13 bits ----
    apply_reset();
    clear_streams();
    for (int l = 0; l < LANES; l++) put_std(l, skew[l]);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hBEEF);
    run_stream(64, -1, -1);
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("ml_lock_edge_%0d", l), lock_edge[l], lk_exp[l]);
      check($sformatf("ml_ofs_%0d", l), dbg_ofs[l], of_exp[l][0]);
      check($sformatf("ml_dv_edge_%0d", l), dv_edge[l], dv_exp[l]);
      check($sformatf("ml_dv_word_%0d", l), dv_word[l], 16'h1234);
    end
    check("ml_dv_early", dv_early, 0);
    check("ml_sb_empty", exp_q.size(), 0);

    // ---- RETRAIN in LOCK, then relock on a later sync run ----
    apply_reset();
    clear_streams();
    put_std(0, 0);
    for (int k = 9; k < 14; k++) put_word(0, 16*k, S_W);
    put_word(0, 224, 16'hABCD);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hABCD);
    run_stream(124, 52, -1);
    check("rt_locked_e51", lk0[51], 1'b1);
    check("rt_locked_e52", lk0[52], 1'b0);
    check("rt_state_e52", st0[52], 2'd0);
    check("rt_dvalid_e52", dv0[52], 1'b0);
    check("rt_dout_hold_e52", dout0[52], 16'h1234);
    check("rt_dvalid_e56", dv0[56], 1'b0);
    check("rt_dout_hold_e100", dout0[100], 16'h1234);
    check("rt_relock_e111", lk0[111], 1'b0);
    check("rt_relock_e112", lk0[112], 1'b1);
    check("rt_dv_e120", dv0[120], 1'b1);
    check("rt_dout_e120", dout0[120], 16'hABCD);
    check("rt_sb_empty", exp_q.size(), 0);

    // ---- reset mid-stream from LOCK, then 100 idle cycles ----
    check("idle_pre_dout", dout[WORD-1:0], 16'hABCD);
    clear_streams();
    run_stream(101, -1, 0);
    check("idle_zero_viol", zero_viol, 0);
    check("idle_lock_edge", lock_edge[0], -1);
    check("idle_dv_edge", dv_edge[0], -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
